// File: rtl/power_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : power_seq_ctrl
// Description : Per-domain power sequencer. Each domain runs its own Moore
//               FSM that walks a rail down (ON -> ISO -> RET -> OFF) and back
//               up (OFF -> PUP -> RREL -> ON). A shared power-up token makes
//               sure that at most one domain is in PUP at a time, which limits
//               inrush current.
// Ports       : CLK      - clock, rising-edge active
//               RST      - asynchronous active-high reset (all domains -> ON)
//               p_flag   - per-domain power-down request (1 = off, 0 = on)
//               pwr_ack  - per-domain power-switch "rail good" acknowledge
//               iso_en   - per-domain isolation enable
//               ret_en   - per-domain retention save enable
//               pse      - per-domain power switch enable (1 = powered)
//               dom_off  - domain is in OFF
//               busy     - domain is in a transitional state
//               err      - sticky power-up acknowledge timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module power_seq_ctrl #(
  parameter int N_DOM       = 2,
  parameter int STEP_CYC    = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_DOM-1:0] p_flag,
  input  logic [N_DOM-1:0] pwr_ack,
  output logic [N_DOM-1:0] iso_en,
  output logic [N_DOM-1:0] ret_en,
  output logic [N_DOM-1:0] pse,
  output logic [N_DOM-1:0] dom_off,
  output logic [N_DOM-1:0] busy,
  output logic [N_DOM-1:0] err
);

  // Counter spans the larger of the dwell and the ack timeout and saturates.
  localparam int CNT_MAX = (STEP_CYC > ACK_TIMEOUT) ? STEP_CYC : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] C_STEP_LST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] C_ACK_LST  = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_ON   = 3'd0,
    ST_ISO  = 3'd1,
    ST_RET  = 3'd2,
    ST_OFF  = 3'd3,
    ST_PUP  = 3'd4,
    ST_RREL = 3'd5
  } state_e;

  logic [N_DOM-1:0] pup_active;
  logic [N_DOM-1:0] tok_req;
  logic [N_DOM-1:0] tok_grant;

  // Token: only when nobody is powering up, the lowest requesting index wins
  // (isolate lowest set bit). A domain still in PUP on the edge it leaves
  // holds the token for that edge, so the next domain enters one edge later.
  assign tok_grant = (|pup_active) ? '0 : (tok_req & (~tok_req + N_DOM'(1)));

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ack_seen_q, ack_seen_d;
    logic             err_q, err_d;
    logic [2:0]       out_d; // {iso_en, ret_en, pse}

    assign cnt_inc       = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + C_CNT_ONE;
    assign pup_active[i] = (state_q == ST_PUP);
    assign tok_req[i]    = (state_q == ST_OFF) && !p_flag[i];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q    <= ST_ON;
        cnt_q      <= '0;
        ack_seen_q <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        ack_seen_q <= ack_seen_d;
        err_q      <= err_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_inc;
      ack_seen_d = ack_seen_q;
      err_d      = err_q;
      unique case (state_q)
        ST_ON: begin
          if (p_flag[i]) state_d = ST_ISO;
        end
        ST_ISO: begin
          if (!p_flag[i])               state_d = ST_ON;
          else if (cnt_q == C_STEP_LST) state_d = ST_RET;
        end
        ST_RET: begin
          if (!p_flag[i])               state_d = ST_RREL;
          else if (cnt_q == C_STEP_LST) state_d = ST_OFF;
        end
        ST_OFF: begin
          if (tok_grant[i]) state_d = ST_PUP;
        end
        ST_PUP: begin
          if (!ack_seen_q) begin
            if (pwr_ack[i]) begin
              // The cycle the ack is first seen is dwell cycle 0.
              ack_seen_d = 1'b1;
              if (STEP_CYC == 1) state_d = ST_RREL;
              else               cnt_d   = C_CNT_ONE;
            end else if (cnt_q == C_ACK_LST) begin
              err_d   = 1'b1;
              state_d = ST_RREL;
            end
          end else if (cnt_q == C_STEP_LST) begin
            state_d = ST_RREL;
          end
        end
        ST_RREL: begin
          if (cnt_q == C_STEP_LST) state_d = ST_ON;
        end
        default: state_d = ST_ON;
      endcase
      // Every state entry starts from a clean counter.
      if (state_d != state_q) begin
        cnt_d      = '0;
        ack_seen_d = 1'b0;
      end
    end

    always_comb begin
      out_d = 3'b001;
      unique case (state_q)
        ST_ON:   out_d = 3'b001;
        ST_ISO:  out_d = 3'b101;
        ST_RET:  out_d = 3'b111;
        ST_OFF:  out_d = 3'b110;
        ST_PUP:  out_d = 3'b111;
        ST_RREL: out_d = 3'b101;
        default: out_d = 3'b001;
      endcase
    end

    assign iso_en[i]  = out_d[2];
    assign ret_en[i]  = out_d[1];
    assign pse[i]     = out_d[0];
    assign dom_off[i] = (state_q == ST_OFF);
    assign busy[i]    = (state_q != ST_ON) && (state_q != ST_OFF);
    assign err[i]     = err_q;
  end

endmodule
`default_nettype wire
